dw_data_sync_mc: RTL and testbench

Multi-channel, toggle-based data receiver for the destination clock domain. Each of `chans` source channels signals new data by inverting a toggle line, holding its data bus stable. The block synchronises each toggle, captures the data into a per-channel holding register, and presents the captured words one at a time on a single valid/ready output port, serviced round-robin. It replaces the single-channel no-acknowledge synchroniser where several slow source-domain producers feed one destination consumer.

---
 rtl/dw_data_sync_mc.sv | 127 ++++++++++++
 tb/tb_dw_data_sync_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dw_data_sync_mc.sv
// dw_data_sync_mc: multi-channel toggle-based data receiver for the
// destination clock domain. Each channel's toggle is synchronised, its data
// captured into a holding register, and the captured words are presented
// one at a time on a valid/ready port, serviced round-robin.
// Optional feature: define DW_DATA_SYNC_MC_OVR_EN to enable sticky per-channel
// overrun flags on ovr_d (cleared via clr_ovr_d); otherwise ovr_d is tied to 0.
module dw_data_sync_mc #(
  parameter int width       = 8,
  parameter int chans       = 4,
  parameter int f_sync_type = 2,
  localparam int chan_w     = (chans > 1) ? $clog2(chans) : 1
) (
  input  logic                     clk_d,
  input  logic                     rst_d,
  input  logic                     init_d_n,
  input  logic [chans-1:0]         toggle_s,
  input  logic [chans*width-1:0]   data_s,
  input  logic                     ready_d,
  input  logic [chans-1:0]         clr_ovr_d,
  output logic                     valid_d,
  output logic [chan_w-1:0]        chan_d,
  output logic [width-1:0]         data_d,
  output logic [chans-1:0]         pend_d,
  output logic [chans-1:0]         ovr_d
);

  logic [chans-1:0]  sync_q [f_sync_type];
  logic [chans-1:0]  tsync;
  logic [chans-1:0]  tprev;
  logic [chans-1:0]  evt;
  logic [chans-1:0]  pend;
  logic [width-1:0]  hold [chans];
  logic [chan_w-1:0] last_grant;
  logic [chan_w-1:0] gnt;
  logic              gnt_vld;
  logic              load;
  logic [chans-1:0]  take_oh;
  logic [chans-1:0]  ovr_set;

  assign tsync   = sync_q[f_sync_type-1];
  assign evt     = tsync ^ tprev;
  assign load    = !valid_d || ready_d;
  assign ovr_set = evt & pend & ~take_oh;
  assign pend_d  = pend;

  // Toggle synchroniser chains; cleared only by the hard reset.
  always_ff @(posedge clk_d or posedge rst_d) begin
    if (rst_d) begin
      for (int s = 0; s < f_sync_type; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= toggle_s;
      for (int s = 1; s < f_sync_type; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Round-robin search for the first pending channel after last_grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    take_oh = '0;
    for (int k = 1; k <= chans; k++) begin
      if (!gnt_vld && pend[(int'(last_grant) + k) % chans]) begin
        gnt_vld = 1'b1;
        gnt     = chan_w'((int'(last_grant) + k) % chans);
      end
    end
    if (load && gnt_vld) take_oh[gnt] = 1'b1;
  end

  // Event capture, pending flags and output register.
  always_ff @(posedge clk_d or posedge rst_d) begin
    if (rst_d) begin
      tprev      <= '0;
      pend       <= '0;
      valid_d    <= 1'b0;
      chan_d     <= '0;
      data_d     <= '0;
      last_grant <= chan_w'(chans - 1);
      for (int i = 0; i < chans; i++) hold[i] <= '0;
    end else if (!init_d_n) begin
      // Absorb the current toggle levels so no stale event fires afterwards.
      tprev      <= tsync;
      pend       <= '0;
      valid_d    <= 1'b0;
      last_grant <= chan_w'(chans - 1);
    end else begin
      tprev <= tsync;
      // A granted channel with a same-cycle event stays pending with new data.
      pend  <= (pend & ~take_oh) | evt;
      for (int i = 0; i < chans; i++) begin
        if (evt[i]) hold[i] <= data_s[i*width +: width];
      end
      if (load) begin
        if (gnt_vld) begin
          valid_d    <= 1'b1;
          chan_d     <= gnt;
          data_d     <= hold[gnt];
          last_grant <= gnt;
        end else begin
          valid_d <= 1'b0;
        end
      end
    end
  end

`ifdef DW_DATA_SYNC_MC_OVR_EN
  logic [chans-1:0] ovr;

  // Sticky overrun flags; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk_d or posedge rst_d) begin
    if (rst_d) begin
      ovr <= '0;
    end else if (!init_d_n) begin
      ovr <= '0;
    end else begin
      ovr <= ovr_set | (ovr & ~clr_ovr_d);
    end
  end

  assign ovr_d = ovr;
`else
  logic unused_ovr;
  assign unused_ovr = ^{clr_ovr_d, ovr_set};
  assign ovr_d      = '0;
`endif

endmodule

// File: tb/tb_dw_data_sync_mc.sv
// Directed testbench for dw_data_sync_mc (width=8, chans=4, f_sync_type=2).
module tb_dw_data_sync_mc;

`ifdef DW_DATA_SYNC_MC_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  logic        clk_d = 1'b0;
  logic        rst_d;
  logic        init_d_n;
  logic [3:0]  toggle_s;
  logic [31:0] data_s;
  logic        ready_d;
  logic [3:0]  clr_ovr_d;
  logic        valid_d;
  logic [1:0]  chan_d;
  logic [7:0]  data_d;
  logic [3:0]  pend_d;
  logic [3:0]  ovr_d;

  int nchk = 0;
  int nerr = 0;

  dw_data_sync_mc #(.width(8), .chans(4), .f_sync_type(2)) dut (
    .clk_d(clk_d), .rst_d(rst_d), .init_d_n(init_d_n), .toggle_s(toggle_s),
    .data_s(data_s), .ready_d(ready_d), .clr_ovr_d(clr_ovr_d),
    .valid_d(valid_d), .chan_d(chan_d), .data_d(data_d), .pend_d(pend_d),
    .ovr_d(ovr_d)
  );

  always #5 clk_d = ~clk_d;

  typedef struct {
    logic [3:0]  tog;
    logic [31:0] dat;
    logic        rdy;
    logic        init_n;
    logic        e_valid;
    logic [1:0]  e_chan;
    logic [7:0]  e_data;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [1:0] ec,
                         input logic [7:0] ed, input logic [3:0] ep, input logic [3:0] eo);
    chk({tag, ".valid"}, 32'(valid_d), 32'(ev));
    chk({tag, ".chan"},  32'(chan_d),  32'(ec));
    chk({tag, ".data"},  32'(data_d),  32'(ed));
    chk({tag, ".pend"},  32'(pend_d),  32'(ep));
    chk({tag, ".ovr"},   32'(ovr_d),   32'(eo));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_d);
      #1;
    end
  endtask

  task automatic set_v(input int i, input logic [3:0] tog, input logic [31:0] dat,
                       input logic rdy, input logic init_n, input logic ev,
                       input logic [1:0] ec, input logic [7:0] ed, input logic [3:0] ep);
    tbl[i].tog = tog;  tbl[i].dat = dat;  tbl[i].rdy = rdy;  tbl[i].init_n = init_n;
    tbl[i].e_valid = ev; tbl[i].e_chan = ec; tbl[i].e_data = ed; tbl[i].e_pend = ep;
  endtask

  logic [3:0] ovr3;

  initial begin
    ovr3 = OVR_ON ? 4'b1000 : 4'b0000;

    // Single word on ch1, then init, then two all-channel bursts.
    set_v( 0, 4'b0010, 32'h0000A500, 1, 1, 0, 0, 8'h00, 4'b0000);
    set_v( 1, 4'b0010, 32'h0000A500, 1, 1, 0, 0, 8'h00, 4'b0000);
    set_v( 2, 4'b0010, 32'h0000A500, 1, 1, 0, 0, 8'h00, 4'b0010);
    set_v( 3, 4'b0010, 32'h0000A500, 1, 1, 1, 1, 8'hA5, 4'b0000);
    set_v( 4, 4'b0010, 32'h0000A500, 1, 1, 0, 1, 8'hA5, 4'b0000);
    set_v( 5, 4'b0010, 32'h0000A500, 1, 0, 0, 1, 8'hA5, 4'b0000);
    set_v( 6, 4'b1101, 32'h13121110, 1, 1, 0, 1, 8'hA5, 4'b0000);
    set_v( 7, 4'b1101, 32'h13121110, 1, 1, 0, 1, 8'hA5, 4'b0000);
    set_v( 8, 4'b1101, 32'h13121110, 1, 1, 0, 1, 8'hA5, 4'b1111);
    set_v( 9, 4'b1101, 32'h13121110, 1, 1, 1, 0, 8'h10, 4'b1110);
    set_v(10, 4'b1101, 32'h13121110, 1, 1, 1, 1, 8'h11, 4'b1100);
    set_v(11, 4'b1101, 32'h13121110, 1, 1, 1, 2, 8'h12, 4'b1000);
    set_v(12, 4'b1101, 32'h13121110, 1, 1, 1, 3, 8'h13, 4'b0000);
    set_v(13, 4'b0010, 32'h23222120, 1, 1, 0, 3, 8'h13, 4'b0000);
    set_v(14, 4'b0010, 32'h23222120, 1, 1, 0, 3, 8'h13, 4'b0000);
    set_v(15, 4'b0010, 32'h23222120, 1, 1, 0, 3, 8'h13, 4'b1111);
    set_v(16, 4'b0010, 32'h23222120, 1, 1, 1, 0, 8'h20, 4'b1110);
    set_v(17, 4'b0010, 32'h23222120, 1, 1, 1, 1, 8'h21, 4'b1100);
    set_v(18, 4'b0010, 32'h23222120, 1, 1, 1, 2, 8'h22, 4'b1000);
    set_v(19, 4'b0010, 32'h23222120, 1, 1, 1, 3, 8'h23, 4'b0000);
    set_v(20, 4'b0010, 32'h23222120, 1, 1, 0, 3, 8'h23, 4'b0000);

    rst_d = 1'b1; init_d_n = 1'b1; toggle_s = '0; data_s = '0;
    ready_d = 1'b1; clr_ovr_d = '0;
    step(2);
    chk_out("reset", 0, 0, 8'h00, 4'b0000, 4'b0000);
    rst_d = 1'b0;
    step(1);

    for (int i = 0; i < 21; i++) begin
      toggle_s = tbl[i].tog; data_s = tbl[i].dat;
      ready_d = tbl[i].rdy;  init_d_n = tbl[i].init_n;
      step(1);
      chk_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_chan,
              tbl[i].e_data, tbl[i].e_pend, 4'b0000);
    end
    init_d_n = 1'b1;

    // Stall: ch0 held on the output while ch2 waits.
    ready_d = 1'b0;
    toggle_s = 4'b0111; data_s[7:0] = 8'h30; data_s[23:16] = 8'h32;
    step(3);
    chk_out("stall_pend", 0, 3, 8'h23, 4'b0101, 4'b0000);
    step(1);
    chk_out("stall_ch0", 1, 0, 8'h30, 4'b0100, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_out($sformatf("stall_hold%0d", i), 1, 0, 8'h30, 4'b0100, 4'b0000);
    end
    ready_d = 1'b1;
    step(1);
    chk_out("stall_ch2", 1, 2, 8'h32, 4'b0000, 4'b0000);
    step(1);
    chk_out("stall_idle", 0, 2, 8'h32, 4'b0000, 4'b0000);

    // Overrun on ch3 while the output is occupied by ch0.
    ready_d = 1'b0;
    toggle_s = 4'b0110; data_s[7:0] = 8'h40;
    step(4);
    chk_out("ovr_ch0", 1, 0, 8'h40, 4'b0000, 4'b0000);
    toggle_s = 4'b1110; data_s[31:24] = 8'h11;
    step(3);
    chk_out("ovr_first", 1, 0, 8'h40, 4'b1000, 4'b0000);
    step(3);
    toggle_s = 4'b0110; data_s[31:24] = 8'h22;
    step(3);
    chk_out("ovr_second", 1, 0, 8'h40, 4'b1000, ovr3);
    ready_d = 1'b1;
    step(1);
    chk_out("ovr_deliver", 1, 3, 8'h22, 4'b0000, ovr3);
    step(1);
    chk_out("ovr_idle", 0, 3, 8'h22, 4'b0000, ovr3);
    clr_ovr_d = 4'b1000;
    step(1);
    clr_ovr_d = 4'b0000;
    chk_out("ovr_clear", 0, 3, 8'h22, 4'b0000, 4'b0000);

    // Grant collision on ch0.
    ready_d = 1'b0;
    toggle_s = 4'b0100; data_s[15:8] = 8'h50;
    step(4);
    chk_out("col_ch1", 1, 1, 8'h50, 4'b0000, 4'b0000);
    toggle_s = 4'b0101; data_s[7:0] = 8'h01;
    step(3);
    chk_out("col_pend", 1, 1, 8'h50, 4'b0001, 4'b0000);
    toggle_s = 4'b0100; data_s[7:0] = 8'h02;
    step(2);
    ready_d = 1'b1;
    step(1);
    chk_out("col_old", 1, 0, 8'h01, 4'b0001, 4'b0000);
    step(1);
    chk_out("col_new", 1, 0, 8'h02, 4'b0000, 4'b0000);
    step(1);
    chk_out("col_idle", 0, 0, 8'h02, 4'b0000, 4'b0000);

    // Soft init with ch1 pending and a ch2 event in flight.
    ready_d = 1'b0;
    toggle_s = 4'b1100; data_s[31:24] = 8'h60;
    step(4);
    chk_out("init_ch3", 1, 3, 8'h60, 4'b0000, 4'b0000);
    toggle_s = 4'b1110; data_s[15:8] = 8'h61;
    step(3);
    chk_out("init_pend", 1, 3, 8'h60, 4'b0010, 4'b0000);
    toggle_s = 4'b1010;
    step(2);
    init_d_n = 1'b0;
    step(1);
    chk_out("init_apply", 0, 3, 8'h60, 4'b0000, 4'b0000);
    init_d_n = 1'b1; ready_d = 1'b1;
    step(3);
    chk_out("init_quiet", 0, 3, 8'h60, 4'b0000, 4'b0000);

    // Asynchronous reset mid-transfer.
    ready_d = 1'b0;
    toggle_s = 4'b1000; data_s[15:8] = 8'h77;
    step(4);
    chk_out("rst_ch1", 1, 1, 8'h77, 4'b0000, 4'b0000);
    toggle_s = 4'b1001; data_s[7:0] = 8'h78;
    step(3);
    chk_out("rst_pend", 1, 1, 8'h77, 4'b0001, 4'b0000);
    #2;
    toggle_s = 4'b0000; rst_d = 1'b1;
    #1;
    chk_out("rst_async", 0, 0, 8'h00, 4'b0000, 4'b0000);
    step(1);
    rst_d = 1'b0;
    step(3);
    chk_out("rst_quiet", 0, 0, 8'h00, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
